// File: rtl/hclk_pkg.sv
// Shared types and helpers for the HCLK gating sequencer.
package hclk_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_SWITCH     = 3'd2,
    ST_RESUME     = 3'd3,
    ST_HALT_DRAIN = 3'd4,
    ST_STOPPED    = 3'd5
  } state_t;

  // Select index width; a single branch still needs one bit.
  function automatic int sel_width(input int n);
    if (n < 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizer, optional inversion, stability counter, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit INV_BTN         = 1'b0
) (
  input  logic clk,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_key;

  // Sync flops start at the idle level so reset release never looks like a transition.
  assign w_key = r_sync2 ^ INV_BTN;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= INV_BTN;
      r_sync2 <= INV_BTN;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted only after an unbroken run of differing samples.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= {CW{1'b0}};
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else if (w_key == r_level) begin
      r_cnt   <= {CW{1'b0}};
      r_press <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= {CW{1'b0}};
      r_level <= w_key;
      r_press <= w_key;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
      r_press <= 1'b0;
    end
  end

  assign level_o = r_level;
  assign press_o = r_press;

endmodule

// File: rtl/hclk_gate_seq.sv
// HCLK gating sequencer: cycles the divided-clock branch select and holds CE low
// for a guard gap on both sides of every branch change.
module hclk_gate_seq
  import hclk_pkg::*;
#(
  parameter int  NUM_HCLK        = 4,
  parameter int  DWELL_CYCLES    = 27000000,
  parameter int  GAP_CYCLES      = 4,
  parameter int  DEBOUNCE_CYCLES = 65536,
  parameter bit  INV_BTN         = 1'b0,
  localparam int SEL_W           = sel_width(NUM_HCLK)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             key_i,
  output logic             ce_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             switch_o,
  output logic             running_o
);

  localparam int               GW        = $clog2(GAP_CYCLES) + 1;
  localparam int               DW        = $clog2(DWELL_CYCLES) + 1;
  localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 32'sd1);
  localparam logic [GW-1:0]    GAP_ONE   = GW'(32'd1);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_CYCLES - 32'sd1);
  localparam logic [DW-1:0]    DWELL_ONE = DW'(32'd1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_HCLK - 32'sd1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(32'd1);

  state_t           r_state;
  state_t           w_next;
  logic [GW-1:0]    r_gap;
  logic [GW-1:0]    w_gap_next;
  logic [DW-1:0]    r_dwell;
  logic [DW-1:0]    w_dwell_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic             r_ce;
  logic             r_switch;
  logic             r_running;
  logic             w_press;
  logic             w_key_level_unused;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INV_BTN        (INV_BTN)
  ) u_key (
    .clk    (clk),
    .rst_i  (rst_i),
    .key_i  (key_i),
    .level_o(w_key_level_unused),
    .press_o(w_press)
  );

  // Counters are cleared whenever they are not counting, so every phase starts at zero.
  always_comb begin
    w_next       = r_state;
    w_gap_next   = {GW{1'b0}};
    w_dwell_next = {DW{1'b0}};
    case (r_state)
      ST_RUN: begin
        if (w_press) begin
          w_next = ST_HALT_DRAIN;
        end else if (r_dwell == DWELL_LAST) begin
          w_next = ST_DRAIN;
        end else begin
          w_dwell_next = r_dwell + DWELL_ONE;
        end
      end
      ST_DRAIN: begin
        if (r_gap == GAP_LAST) begin
          w_next = ST_SWITCH;
        end else begin
          w_gap_next = r_gap + GAP_ONE;
        end
      end
      ST_SWITCH: begin
        w_next = ST_RESUME;
      end
      ST_RESUME: begin
        if (r_gap == GAP_LAST) begin
          w_next = ST_RUN;
        end else begin
          w_gap_next = r_gap + GAP_ONE;
        end
      end
      ST_HALT_DRAIN: begin
        if (r_gap == GAP_LAST) begin
          w_next = ST_STOPPED;
        end else begin
          w_gap_next = r_gap + GAP_ONE;
        end
      end
      ST_STOPPED: begin
        if (w_press) begin
          w_next = ST_RESUME;
        end else begin
          w_next = ST_STOPPED;
        end
      end
      default: begin
        w_next = ST_RESUME;
      end
    endcase
  end

  // The select advances only on entry to SWITCH, when CE has already been low for the gap.
  always_comb begin
    w_sel_next = r_sel;
    if (w_next == ST_SWITCH) begin
      if (r_sel == SEL_LAST) begin
        w_sel_next = {SEL_W{1'b0}};
      end else begin
        w_sel_next = r_sel + SEL_ONE;
      end
    end else begin
      w_sel_next = r_sel;
    end
  end

  // Outputs are decoded from the next state and registered so CE cannot glitch.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_RESUME;
      r_gap     <= {GW{1'b0}};
      r_dwell   <= {DW{1'b0}};
      r_sel     <= {SEL_W{1'b0}};
      r_ce      <= 1'b0;
      r_switch  <= 1'b0;
      r_running <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_gap     <= w_gap_next;
      r_dwell   <= w_dwell_next;
      r_sel     <= w_sel_next;
      r_ce      <= (w_next == ST_RUN);
      r_switch  <= (w_next == ST_SWITCH);
      r_running <= (w_next != ST_HALT_DRAIN) && (w_next != ST_STOPPED);
    end
  end

  assign ce_o      = r_ce;
  assign sel_o     = r_sel;
  assign switch_o  = r_switch;
  assign running_o = r_running;

endmodule

// File: tb/tb_hclk_gate_seq.sv
// Directed bench for hclk_gate_seq with a timeline-based reference model.
module tb_hclk_gate_seq;

  localparam int NUM_HCLK = 3;
  localparam int DWELL    = 10;
  localparam int GAP      = 2;
  localparam int DEB      = 4;
  localparam int PERIOD   = GAP + DWELL + GAP + 1;

  logic       clk   = 1'b0;
  logic       rst_i = 1'b1;
  logic       key_i = 1'b0;
  logic       ce_o;
  logic [1:0] sel_o;
  logic       switch_o;
  logic       running_o;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_no  = 0;
  bit chk_en  = 1'b0;

  hclk_gate_seq #(
    .NUM_HCLK       (NUM_HCLK),
    .DWELL_CYCLES   (DWELL),
    .GAP_CYCLES     (GAP),
    .DEBOUNCE_CYCLES(DEB),
    .INV_BTN        (1'b0)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .key_i    (key_i),
    .ce_o     (ce_o),
    .sel_o    (sel_o),
    .switch_o (switch_o),
    .running_o(running_o)
  );

  always #5 clk = ~clk;

  // Model: while cycling, outputs follow from time since the last resume origin.
  typedef enum int {M_CYCLE, M_HALT, M_STOP} mmode_t;
  mmode_t m_mode  = M_CYCLE;
  int     m_t     = 0;
  int     m_h     = 0;
  int     m_base  = 0;
  bit     m_level = 1'b0;
  bit     m_press = 1'b0;
  bit     kh[DEB+2];

  function automatic int exp_sel();
    if (m_mode == M_CYCLE) return (m_base + (m_t + 1) / PERIOD) % NUM_HCLK;
    else return m_base;
  endfunction

  function automatic int exp_ce();
    int p;
    if (m_mode != M_CYCLE) return 0;
    p = m_t % PERIOD;
    return (p >= GAP && p < GAP + DWELL) ? 1 : 0;
  endfunction

  function automatic int exp_sw();
    if (m_mode != M_CYCLE) return 0;
    return ((m_t % PERIOD) == PERIOD - 1) ? 1 : 0;
  endfunction

  function automatic int exp_run();
    return (m_mode == M_CYCLE) ? 1 : 0;
  endfunction

  initial begin
    for (int i = 0; i < DEB + 2; i++) kh[i] = 1'b0;
    forever begin
      @(posedge clk or posedge rst_i);
      if (rst_i) begin
        m_mode = M_CYCLE; m_t = 0; m_h = 0; m_base = 0;
        m_level = 1'b0; m_press = 1'b0;
        for (int i = 0; i < DEB + 2; i++) kh[i] = 1'b0;
      end else begin
        bit all_diff;
        int p;
        if (m_mode == M_CYCLE) begin
          p = m_t % PERIOD;
          if (m_press && p >= GAP && p < GAP + DWELL) begin
            m_base = exp_sel();
            m_mode = M_HALT;
            m_h    = 0;
          end else begin
            m_t++;
          end
        end else if (m_mode == M_HALT) begin
          if (m_h == GAP - 1) m_mode = M_STOP;
          else m_h++;
        end else begin
          if (m_press) begin
            m_mode = M_CYCLE;
            m_t    = 0;
          end
        end
        for (int i = DEB + 1; i > 0; i--) kh[i] = kh[i-1];
        kh[0] = key_i;
        all_diff = 1'b1;
        for (int i = 2; i <= DEB + 1; i++) if (kh[i] == m_level) all_diff = 1'b0;
        m_press = all_diff && !m_level;
        if (all_diff) m_level = !m_level;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_no, act, exp);
  endtask

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_ce", {31'd0, ce_o}, exp_ce());
        check("model_sel", {30'd0, sel_o}, exp_sel());
        check("model_switch", {31'd0, switch_o}, exp_sw());
        check("model_running", {31'd0, running_o}, exp_run());
      end
    end
  end

  task automatic go_to(input int target);
    while (cyc_no < target) begin
      @(negedge clk);
      cyc_no++;
    end
  endtask

  task automatic point1_pins();
    go_to(1);  check("p1_ce_gap", {31'd0, ce_o}, 32'd0);
    go_to(2);  check("p1_ce_run", {31'd0, ce_o}, 32'd1);
    go_to(14); check("p1_switch", {31'd0, switch_o}, 32'd1);
               check("p1_sel", {30'd0, sel_o}, 32'd1);
    go_to(17); check("p1_ce_back", {31'd0, ce_o}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ce", {31'd0, ce_o}, 32'd0);
    check("rst_sel", {30'd0, sel_o}, 32'd0);
    check("rst_switch", {31'd0, switch_o}, 32'd0);
    check("rst_running", {31'd0, running_o}, 32'd1);
    rst_i = 1'b0; cyc_no = 0; chk_en = 1'b1;

    point1_pins();
    go_to(44); check("wrap_sel0", {30'd0, sel_o}, 32'd0);
               check("wrap_switch", {31'd0, switch_o}, 32'd1);
    go_to(59); check("wrap_sel1", {30'd0, sel_o}, 32'd1);

    // bouncing key, final rise driven at cycle 64
    go_to(60); key_i = 1'b1;
    go_to(61); key_i = 1'b0;
    go_to(62); key_i = 1'b1;
    go_to(63); key_i = 1'b0;
    go_to(64); key_i = 1'b1;
    go_to(70); check("halt_ce_before", {31'd0, ce_o}, 32'd1);
    go_to(71); check("halt_ce", {31'd0, ce_o}, 32'd0);
               check("halt_running", {31'd0, running_o}, 32'd0);
    go_to(80); check("stop_sel", {30'd0, sel_o}, 32'd1);
               check("stop_running", {31'd0, running_o}, 32'd0);
    key_i = 1'b0;

    go_to(90);  key_i = 1'b1;
    go_to(96);  check("still_stopped", {31'd0, running_o}, 32'd0);
    go_to(97);  check("resume_running", {31'd0, running_o}, 32'd1);
                check("resume_ce", {31'd0, ce_o}, 32'd0);
    go_to(99);  check("resume_ce_on", {31'd0, ce_o}, 32'd1);
                check("resume_sel", {30'd0, sel_o}, 32'd1);
    go_to(108); check("full_dwell_ce", {31'd0, ce_o}, 32'd1);
    go_to(109); check("drain_after_dwell", {31'd0, ce_o}, 32'd0);
    go_to(111); check("resume_switch", {31'd0, switch_o}, 32'd1);
                check("resume_switch_sel", {30'd0, sel_o}, 32'd2);
    key_i = 1'b0;

    // press pulse lands on the dwell-expiry cycle 123
    go_to(117); key_i = 1'b1;
    go_to(123); check("expiry_ce", {31'd0, ce_o}, 32'd1);
    go_to(124); check("expiry_halt", {31'd0, running_o}, 32'd0);
                check("expiry_no_switch", {31'd0, switch_o}, 32'd0);
                check("expiry_sel", {30'd0, sel_o}, 32'd2);
    go_to(126); key_i = 1'b0;

    go_to(134); key_i = 1'b1;
    go_to(141); check("resume2_running", {31'd0, running_o}, 32'd1);
    go_to(145); key_i = 1'b0;
    go_to(153); check("drain_ce", {31'd0, ce_o}, 32'd0);
                check("drain_sel", {30'd0, sel_o}, 32'd2);
    #2 rst_i = 1'b1;
    #1;
    check("async_ce", {31'd0, ce_o}, 32'd0);
    check("async_sel", {30'd0, sel_o}, 32'd0);
    check("async_running", {31'd0, running_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0; cyc_no = 0;
    point1_pins();
    go_to(20);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
